// File: rtl/sgb_joypad_mux_if.sv
// Joypad-side bundle for sgb_joypad_mux: select lines, decoded nibble,
// per-player buttons, MLT_REQ mode and the current player index.
interface sgb_joypad_mux_if #(
    parameter int PLAYERS = 4,
    parameter int IDX_W   = 2
);
    logic                   clk_en;
    logic [1:0]             joy_p54;
    logic [3:0]             joy_din;
    logic [PLAYERS*8-1:0]   joy;
    logic [1:0]             mlt_req;
    logic [IDX_W-1:0]       player_idx;

    modport master (
        output clk_en,
        output joy_p54,
        output joy,
        output mlt_req,
        input  joy_din,
        input  player_idx
    );

    modport slave (
        input  clk_en,
        input  joy_p54,
        input  joy,
        input  mlt_req,
        output joy_din,
        output player_idx
    );
endinterface

// File: rtl/sgb_joypad_mux.sv
// Multi-player SGB joypad front-end: P14/P15 nibble decode plus MLT_REQ player rotation.
// Optional feature macro SGB_JOY_SOCD_EN: per-player SOCD cleaning before decode.
module sgb_joypad_mux #(
    parameter int PLAYERS = 4,
    parameter int IDX_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    sgb_joypad_mux_if.slave   bus
);
    localparam int AW = IDX_W + 1;

    logic [1:0]       r_mlt_req;
    logic [1:0]       r_mlt_req_d;
    logic             r_p15;
    logic             r_p15_rise;
    logic [IDX_W-1:0] r_idx;
    logic [3:0]       r_joy_din;

    logic             w_mlt_chg;
    logic [AW-1:0]    w_mode;
    logic [AW-1:0]    w_active;
    logic [AW-1:0]    w_idx_inc;
    logic [7:0]       w_sel;
    logic [7:0]       w_b;
    logic [3:0]       w_nib;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mlt_req   <= '0;
            r_mlt_req_d <= '0;
        end else begin
            r_mlt_req   <= bus.mlt_req;
            r_mlt_req_d <= r_mlt_req;
        end
    end

    assign w_mlt_chg = (r_mlt_req != r_mlt_req_d);

    always_comb begin
        case (r_mlt_req)
            2'd1:    w_mode = AW'(2);
            2'd3:    w_mode = AW'(4);
            default: w_mode = AW'(1);
        endcase
        w_active = (w_mode > AW'(PLAYERS)) ? AW'(PLAYERS) : w_mode;
    end

    // Edge flag is registered, so the index moves one clk after the detecting sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p15      <= 1'b1;
            r_p15_rise <= 1'b0;
        end else begin
            r_p15_rise <= bus.clk_en & bus.joy_p54[1] & ~r_p15;
            if (bus.clk_en) begin
                r_p15 <= bus.joy_p54[1];
            end
        end
    end

    assign w_idx_inc = {1'b0, r_idx} + AW'(1);

    // An MLT_REQ change takes priority over a coincident P15 edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= '0;
        end else if (w_mlt_chg || (w_active == AW'(1))) begin
            r_idx <= '0;
        end else if (r_p15_rise) begin
            r_idx <= (w_idx_inc >= w_active) ? '0 : w_idx_inc[IDX_W-1:0];
        end
    end

    always_comb begin
        w_sel = '0;
        for (int unsigned p = 0; p < PLAYERS; p++) begin
            if (r_idx == IDX_W'(p)) begin
                w_sel = bus.joy[p*8 +: 8];
            end
        end
    end

`ifdef SGB_JOY_SOCD_EN
    always_comb begin
        w_b = w_sel;
        if (w_sel[0] && w_sel[1]) begin
            w_b[1:0] = '0;
        end
        if (w_sel[2] && w_sel[3]) begin
            w_b[3:2] = '0;
        end
    end
`else
    assign w_b = w_sel;
`endif

    always_comb begin
        case (bus.joy_p54)
            2'b10:   w_nib = ~w_b[3:0];
            2'b01:   w_nib = ~w_b[7:4];
            2'b00:   w_nib = ~(w_b[3:0] | w_b[7:4]);
            default: w_nib = (w_active > AW'(1)) ? (4'hF - 4'(r_idx)) : 4'hF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_joy_din <= 4'hF;
        end else begin
            r_joy_din <= w_nib;
        end
    end

    assign bus.joy_din    = r_joy_din;
    assign bus.player_idx = r_idx;
endmodule

// File: tb/tb_sgb_joypad_mux.sv
// Scoreboard bench for sgb_joypad_mux: a 4-player and a 2-player instance share stimulus.
// Honours SGB_JOY_SOCD_EN when choosing the opposing-direction expectation.
module tb_sgb_joypad_mux;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        tb_clk_en;
    logic [1:0]  tb_p54;
    logic [1:0]  tb_mlt;
    logic [31:0] tb_joy;

    sgb_joypad_mux_if #(.PLAYERS(4)) if4 ();
    sgb_joypad_mux_if #(.PLAYERS(2)) if2 ();

    assign if4.clk_en  = tb_clk_en;
    assign if4.joy_p54 = tb_p54;
    assign if4.mlt_req = tb_mlt;
    assign if4.joy     = tb_joy;
    assign if2.clk_en  = tb_clk_en;
    assign if2.joy_p54 = tb_p54;
    assign if2.mlt_req = tb_mlt;
    assign if2.joy     = tb_joy[15:0];

    sgb_joypad_mux #(.PLAYERS(4)) u_dut4 (.clk(clk), .reset(reset), .bus(if4));
    sgb_joypad_mux #(.PLAYERS(2)) u_dut2 (.clk(clk), .reset(reset), .bus(if2));

`ifdef SGB_JOY_SOCD_EN
    localparam logic [3:0] SOCD_EXP = 4'hF;
`else
    localparam logic [3:0] SOCD_EXP = 4'hC;
`endif

    localparam int unsigned S_DIN4 = 0, S_IDX4 = 1, S_IDX2 = 2, S_DIN2 = 3;

    typedef struct {
        string       tag;
        int unsigned sig;
        logic [3:0]  exp;
    } item_t;

    item_t sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_val(input string tag, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic expect_val(input string tag, input int unsigned sig, input logic [3:0] v);
        item_t it;
        it.tag = tag;
        it.sig = sig;
        it.exp = v;
        sb.push_back(it);
    endtask

    task automatic drain();
        item_t it;
        logic [3:0] act;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            case (it.sig)
                S_DIN4:  act = if4.joy_din;
                S_IDX4:  act = {2'b00, if4.player_idx};
                S_IDX2:  act = {2'b00, if2.player_idx};
                default: act = if2.joy_din;
            endcase
            check_val(it.tag, act, it.exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Low then high P15 on two enabled samples; returns right after the detecting sample.
    task automatic p15_edge();
        tb_clk_en = 1'b1;
        tb_p54    = 2'b01;
        tick(1);
        tb_p54    = 2'b11;
        tick(1);
        tb_clk_en = 1'b0;
    endtask

    function automatic logic [3:0] model_nib(input logic [1:0] p54, input logic [7:0] b,
                                             input logic [1:0] idx, input int unsigned n);
        logic [7:0] c;
        c = b;
`ifdef SGB_JOY_SOCD_EN
        if (b[0] && b[1]) c[1:0] = 2'b00;
        if (b[2] && b[3]) c[3:2] = 2'b00;
`endif
        case (p54)
            2'b10:   return ~c[3:0];
            2'b01:   return ~c[7:4];
            2'b00:   return ~(c[3:0] | c[7:4]);
            default: return (n > 1) ? (4'hF - {2'b00, idx}) : 4'hF;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [1:0] m4, m2;
        logic [1:0] rp;

        reset     = 1'b1;
        tb_clk_en = 1'b0;
        tb_p54    = 2'b11;
        tb_mlt    = 2'd0;
        tb_joy    = '0;
        tick(2);
        expect_val("rst_idx4", S_IDX4, 4'h0);
        expect_val("rst_din4", S_DIN4, 4'hF);
        expect_val("rst_idx2", S_IDX2, 4'h0);
        drain();
        reset = 1'b0;
        tick(1);
        expect_val("idle_din4", S_DIN4, 4'hF);
        expect_val("idle_idx4", S_IDX4, 4'h0);
        drain();

        // Rotation: 4-player wraps at 4, 2-player instance clamps and wraps at 2.
        tb_mlt = 2'd3;
        tick(3);
        m4 = 2'd0;
        m2 = 2'd0;
        for (int k = 0; k < 5; k++) begin
            p15_edge();
            tick(1);
            m4 = (m4 == 2'd3) ? 2'd0 : m4 + 2'd1;
            m2 = (m2 == 2'd1) ? 2'd0 : m2 + 2'd1;
            expect_val($sformatf("rot_idx4_%0d", k), S_IDX4, {2'b00, m4});
            expect_val($sformatf("rot_idx2_%0d", k), S_IDX2, {2'b00, m2});
            drain();
            tick(1);
            expect_val($sformatf("rot_din4_%0d", k), S_DIN4, 4'hF - {2'b00, m4});
            expect_val($sformatf("rot_din2_%0d", k), S_DIN2, 4'hF - {2'b00, m2});
            drain();
        end

        tb_p54 = 2'b01;
        tick(2);
        tb_p54 = 2'b11;
        tick(2);
        expect_val("noen_idx4", S_IDX4, 4'h1);
        drain();

        // Two-player mode with player 1 holding start+right.
        tb_joy[15:8] = 8'h81;
        tb_mlt = 2'd1;
        tick(1);
        expect_val("mlt_hold_idx4", S_IDX4, 4'h1);
        drain();
        tick(1);
        expect_val("mlt_clr_idx4", S_IDX4, 4'h0);
        expect_val("mlt_clr_idx2", S_IDX2, 4'h0);
        drain();
        p15_edge();
        tick(1);
        expect_val("p1_idx4", S_IDX4, 4'h1);
        drain();
        tb_p54 = 2'b10;
        tick(1);
        expect_val("p1_dir", S_DIN4, 4'hE);
        drain();
        tb_p54 = 2'b01;
        tick(1);
        expect_val("p1_btn", S_DIN4, 4'h7);
        drain();
        tb_p54 = 2'b00;
        tick(1);
        expect_val("p1_both", S_DIN4, 4'h6);
        drain();

        // P15 rise coincident with an mlt_req change: the change wins.
        tb_clk_en = 1'b1;
        tb_p54    = 2'b01;
        tick(1);
        tb_mlt = 2'd3;
        tb_p54 = 2'b11;
        tick(1);
        tb_clk_en = 1'b0;
        tick(1);
        expect_val("coinc_idx4", S_IDX4, 4'h0);
        drain();
        tick(1);
        expect_val("coinc_after_idx4", S_IDX4, 4'h0);
        drain();

        tb_joy[7:0] = 8'h03;
        tb_p54 = 2'b10;
        tick(1);
        expect_val("socd_din4", S_DIN4, SOCD_EXP);
        drain();

        for (int k = 0; k < 8; k++) begin
            tb_joy = $urandom;
            rp = 2'($urandom_range(0, 3));
            tb_p54 = rp;
            expect_val($sformatf("rand_din4_%0d", k), S_DIN4, model_nib(rp, tb_joy[7:0], 2'd0, 4));
            tick(1);
            drain();
        end
        tb_joy = '0;
        tb_p54 = 2'b11;

        tb_mlt = 2'd0;
        tick(3);
        p15_edge();
        tick(2);
        expect_val("single_idx4", S_IDX4, 4'h0);
        expect_val("single_din4", S_DIN4, 4'hF);
        drain();

        // Reset mid-sequence with P15 last sampled low.
        tb_mlt = 2'd3;
        tick(3);
        p15_edge();
        tick(1);
        expect_val("pre_rst_idx4", S_IDX4, 4'h1);
        drain();
        tb_clk_en = 1'b1;
        tb_p54    = 2'b01;
        tick(1);
        tb_clk_en = 1'b0;
        tb_p54    = 2'b11;
        reset     = 1'b1;
        tick(1);
        expect_val("mid_rst_idx4", S_IDX4, 4'h0);
        expect_val("mid_rst_din4", S_DIN4, 4'hF);
        drain();
        reset = 1'b0;
        tick(2);
        tb_clk_en = 1'b1;
        tick(1);
        tb_clk_en = 1'b0;
        tick(2);
        expect_val("post_rst_noedge_idx4", S_IDX4, 4'h0);
        drain();
        p15_edge();
        tick(1);
        expect_val("post_rst_edge_idx4", S_IDX4, 4'h1);
        drain();
        tick(1);
        expect_val("post_rst_edge_din4", S_DIN4, 4'hE);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
